audio_packet_picker: RTL

Per-frame HDMI data-island packet scheduler in the `clk_pixel` domain. It sits between the clock-crossing audio sample buffer (upstream, valid/ready sample stream) and the `hdmi` core (downstream, consuming `packet_type` plus audio subpacket payload on each `packet_enable`). Each video frame it sends, in priority order:

- Audio Clock Regeneration (ACR)
- Audio InfoFrame
- Audio Sample packets carrying up to four accumulated stereo samples, tagged with IEC 60958 block-start flags
- Null packets otherwise

---
 rtl/hdmi_audio_pkg.sv | 35 +++
 rtl/iec60958_frame_counter.sv | 47 ++++
 rtl/audio_packet_picker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_audio_pkg
// Description : Shared HDMI data-island packet codes, IEC 60958 block length
//               and the packet-selection encoding used by the audio picker.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_audio_pkg;

    localparam logic [7:0] PKT_NULL            = 8'h00;
    localparam logic [7:0] PKT_ACR             = 8'h01;
    localparam logic [7:0] PKT_AUDIO_SAMPLE    = 8'h02;
    localparam logic [7:0] PKT_AUDIO_INFOFRAME = 8'h84;

    localparam int IEC_BLOCK_FRAMES = 192;

    typedef enum logic [1:0] {
        SEL_NULL  = 2'd0,
        SEL_ACR   = 2'd1,
        SEL_INFO  = 2'd2,
        SEL_AUDIO = 2'd3
    } pkt_sel_e;

    // Header type byte for a packet selection
    function automatic logic [7:0] pkt_code(input pkt_sel_e sel);
        case (sel)
            SEL_ACR:   return PKT_ACR;
            SEL_INFO:  return PKT_AUDIO_INFOFRAME;
            SEL_AUDIO: return PKT_AUDIO_SAMPLE;
            default:   return PKT_NULL;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/iec60958_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : iec60958_frame_counter
// Description : Mod-192 IEC 60958 frame index. Advances by the number of
//               samples emitted (0..4) and flags which of the four subpacket
//               slots carries frame 0 of the block (the B flag).
// Revision    : 1.0 - initial release
// ============================================================================
module iec60958_frame_counter
    import hdmi_audio_pkg::*;
(
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       advance_i,
    input  logic [2:0] advance_n_i,
    input  logic [3:0] present_i,
    output logic [3:0] block_start_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_sum;

    // cnt_q <= 191 and advance <= 4, so the raw sum fits in 8 bits
    assign cnt_sum = cnt_q + {5'd0, advance_n_i};
    assign cnt_d   = (cnt_sum >= 8'(IEC_BLOCK_FRAMES))
                   ? cnt_sum - 8'(IEC_BLOCK_FRAMES) : cnt_sum;

    // Frame index register, advanced once per emitted audio packet
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
        end else if (advance_i) begin
            cnt_q <= cnt_d;
        end
    end

    // Slot i is frame (cnt + i) mod 192; it starts a block when that is 0
    for (genvar i = 0; i < 4; i++) begin : g_slot_flag
        logic [7:0] w_idx;
        assign w_idx            = cnt_q + 8'(i);
        assign block_start_o[i] = present_i[i] &&
                                  ((w_idx == 8'd0) || (w_idx == 8'(IEC_BLOCK_FRAMES)));
    end

endmodule
`default_nettype wire

// File: rtl/audio_packet_picker.sv
`default_nettype none
// ============================================================================
// Module      : audio_packet_picker
// Description : Per-frame HDMI data-island packet scheduler. Sends ACR, then
//               (optionally) the Audio InfoFrame, then audio sample packets
//               of up to four buffered samples, else null packets.
//               Build option: define AUDIO_INFOFRAME_EN to send the Audio
//               InfoFrame once per frame after ACR.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_packet_picker
    import hdmi_audio_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int CHANNELS        = 2
) (
    input  logic                                  clk_pixel,
    input  logic                                  reset,
    input  logic                                  frame_start,
    input  logic                                  packet_enable,
    input  logic                                  sample_valid,
    output logic                                  sample_ready,
    input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0]   sample_word,
    output logic [7:0]                            packet_type,
    output logic [4*CHANNELS*AUDIO_BIT_WIDTH-1:0] audio_sample_word,
    output logic [3:0]                            audio_sample_word_present,
    output logic [3:0]                            audio_block_start,
    output logic [2:0]                            samples_held
);

    localparam int SW = CHANNELS * AUDIO_BIT_WIDTH;

    logic [SW-1:0]   acc_q [4];
    logic [2:0]      held_q, held_d;
    logic            acr_sent_q, acr_sent_d;
`ifdef AUDIO_INFOFRAME_EN
    logic            info_sent_q, info_sent_d;
`endif
    logic [7:0]      pkt_type_q;
    logic [3:0]      present_q;
    logic [3:0]      bstart_q;
    logic [4*SW-1:0] word_q;

    pkt_sel_e        sel;
    logic            transfer;
    logic            emit;
    logic [3:0]      present_mask;
    logic [3:0]      slot_bstart;

    assign sample_ready = !reset && (held_q != 3'd4);
    assign transfer     = sample_valid && sample_ready;
    assign emit         = packet_enable && (sel == SEL_AUDIO);

    // Packet priority; a same-cycle frame_start clears the flags first
    always_comb begin
        acr_sent_d = frame_start ? 1'b0 : acr_sent_q;
`ifdef AUDIO_INFOFRAME_EN
        info_sent_d = frame_start ? 1'b0 : info_sent_q;
`endif
        if (!acr_sent_d) begin
            sel = SEL_ACR;
`ifdef AUDIO_INFOFRAME_EN
        end else if (!info_sent_d) begin
            sel = SEL_INFO;
`endif
        end else if (held_q != 3'd0) begin
            sel = SEL_AUDIO;
        end else begin
            sel = SEL_NULL;
        end
        if (packet_enable && (sel == SEL_ACR)) begin
            acr_sent_d = 1'b1;
        end
`ifdef AUDIO_INFOFRAME_EN
        if (packet_enable && (sel == SEL_INFO)) begin
            info_sent_d = 1'b1;
        end
`endif
    end

    // Occupancy and the slots that an audio packet would carry
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            present_mask[i] = (3'(i) < held_q);
        end
        if (emit) begin
            held_d = transfer ? 3'd1 : 3'd0;
        end else if (transfer) begin
            held_d = held_q + 3'd1;
        end else begin
            held_d = held_q;
        end
    end

    // Accumulator: a sample arriving during emission starts the next packet
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            held_q     <= 3'd0;
            acr_sent_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            held_q     <= held_d;
            acr_sent_q <= acr_sent_d;
            if (transfer) begin
                if (emit) begin
                    acc_q[0] <= sample_word;
                end else begin
                    acc_q[held_q[1:0]] <= sample_word;
                end
            end
        end
    end

`ifdef AUDIO_INFOFRAME_EN
    // InfoFrame-sent flag, cleared each frame
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            info_sent_q <= 1'b0;
        end else begin
            info_sent_q <= info_sent_d;
        end
    end
`endif

    iec60958_frame_counter u_frame_counter (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .advance_i     (emit),
        .advance_n_i   (held_q),
        .present_i     (present_mask),
        .block_start_o (slot_bstart)
    );

    // Registered packet outputs, updated only on packet_enable
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            pkt_type_q <= PKT_NULL;
            present_q  <= 4'd0;
            bstart_q   <= 4'd0;
            word_q     <= '0;
        end else if (packet_enable) begin
            pkt_type_q <= pkt_code(sel);
            if (sel == SEL_AUDIO) begin
                present_q <= present_mask;
                bstart_q  <= slot_bstart;
                for (int i = 0; i < 4; i++) begin
                    word_q[i*SW +: SW] <= present_mask[i] ? acc_q[i] : '0;
                end
            end else begin
                present_q <= 4'd0;
                bstart_q  <= 4'd0;
            end
        end
    end

    assign packet_type               = pkt_type_q;
    assign audio_sample_word         = word_q;
    assign audio_sample_word_present = present_q;
    assign audio_block_start         = bstart_q;
    assign samples_held              = held_q;

endmodule
`default_nettype wire
